// File: rtl/fifo_uart_tx_if.sv
// Pop-side handshake between the serial transmitter (master) and the FIFO
// feeding it (slave).
interface fifo_uart_tx_if #(
    parameter int size = 8
);
    logic            READ;
    logic            F_EMPTY_N;
    logic [size-1:0] FIFO_DATA;

    modport master (output READ, input F_EMPTY_N, input FIFO_DATA);
    modport slave  (input READ, output F_EMPTY_N, output FIFO_DATA);
endinterface

// File: rtl/fifo_uart_tx.sv
// Asynchronous serial transmitter that drains an upstream FIFO one word at a
// time and sends each word LSB-first as start/data/parity/stop frames.
module fifo_uart_tx #(
    parameter int size      = 8,
    parameter int CLK_DIV   = 434,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic           CLOCK,
    input  logic           RESET_N,
    input  logic           CLEAR_N,
    input  logic           ENABLE,
    fifo_uart_tx_if.master fifo,
    output logic           TX,
    output logic           BUSY
);
    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int BIT_W  = $clog2(size);

    typedef enum logic [2:0] {IDLE, FETCH, START, DATA, PAR, STOP} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [BAUD_W-1:0] r_baudCnt;
    logic [BIT_W-1:0]  r_bitCnt;
    logic [size-1:0]   r_shift;
    logic              r_parity;
    logic              r_tx;
    logic              w_read;
    logic              w_txNext;
    logic              w_baudEnd;
    logic              w_counting;
    logic              w_stateChange;

    assign w_baudEnd     = (r_baudCnt == BAUD_W'(CLK_DIV - 1));
    assign w_counting    = (r_state == START) || (r_state == DATA) ||
                           (r_state == PAR)   || (r_state == STOP);
    assign w_stateChange = (w_next != r_state);

    // TX is registered from the next state so the line level changes exactly
    // on the clock edge that enters each bit.
    always_comb begin
        w_next   = r_state;
        w_read   = 1'b0;
        w_txNext = 1'b1;
        case (r_state)
            IDLE: begin
                w_read = ENABLE & fifo.F_EMPTY_N;
                if (w_read)
                    w_next = FETCH;
            end
            FETCH: w_next = START;
            START: if (w_baudEnd) w_next = DATA;
            DATA: begin
                if (w_baudEnd && (r_bitCnt == BIT_W'(size - 1)))
                    w_next = (PARITY != 0) ? PAR : STOP;
            end
            PAR: if (w_baudEnd) w_next = STOP;
            STOP: begin
                if (w_baudEnd && (r_bitCnt == BIT_W'(STOP_BITS - 1)))
                    w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
        if (!CLEAR_N) begin
            w_next = IDLE;
            w_read = 1'b0;
        end
        case (w_next)
            START: w_txNext = 1'b0;
            DATA:  w_txNext = (r_state == DATA && w_baudEnd) ? r_shift[1] : r_shift[0];
            PAR:   w_txNext = r_parity;
            default: w_txNext = 1'b1;
        endcase
    end

    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state   <= IDLE;
            r_baudCnt <= '0;
            r_bitCnt  <= '0;
            r_shift   <= '0;
            r_parity  <= 1'b0;
            r_tx      <= 1'b1;
        end else begin
            r_state <= w_next;
            r_tx    <= w_txNext;
            if (!CLEAR_N) begin
                r_baudCnt <= '0;
                r_bitCnt  <= '0;
                r_shift   <= '0;
                r_parity  <= 1'b0;
            end else begin
                if (w_stateChange || w_baudEnd || !w_counting)
                    r_baudCnt <= '0;
                else
                    r_baudCnt <= r_baudCnt + BAUD_W'(1);

                // Bit counter doubles as the stop-bit counter.
                if (w_stateChange)
                    r_bitCnt <= '0;
                else if (w_baudEnd && (r_state == DATA || r_state == STOP))
                    r_bitCnt <= r_bitCnt + BIT_W'(1);

                if (r_state == FETCH) begin
                    r_shift  <= fifo.FIFO_DATA;
                    r_parity <= (PARITY == 2) ? ~(^fifo.FIFO_DATA) : (^fifo.FIFO_DATA);
                end else if (r_state == DATA && w_baudEnd) begin
                    r_shift <= r_shift >> 1;
                end
            end
        end
    end

    assign fifo.READ = w_read;
    assign TX        = r_tx;
    assign BUSY      = (r_state != IDLE) | w_read;
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three parity/stop configurations share one word log
// and are each compared cycle by cycle against a frame-level reference.
module tb_fifo_uart_tx;
    localparam int CLK_DIV = 4;

    logic CLOCK   = 1'b0;
    logic RESET_N = 1'b0;
    logic CLEAR_N = 1'b1;
    logic ENABLE  = 1'b0;

    logic [7:0] wordLog[$];
    int wrCount     = 0;
    int vectorCount = 0;
    int missCount   = 0;

    always #5 CLOCK = ~CLOCK;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectorCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    for (genvar G = 0; G < 3; G++) begin : gInst
        localparam int PAR   = G;
        localparam int STOPS = (G == 1) ? 2 : 1;
        localparam int NBITS = 1 + 8 + ((PAR != 0) ? 1 : 0) + STOPS;

        fifo_uart_tx_if #(.size(8)) bus ();
        logic tx;
        logic busy;
        int   rdPtr    = 0;
        int   modelPtr = 0;
        int   dutReads = 0;
        bit   expTx[$];

        fifo_uart_tx #(
            .size(8), .CLK_DIV(CLK_DIV), .PARITY(PAR), .STOP_BITS(STOPS)
        ) dut (
            .CLOCK(CLOCK), .RESET_N(RESET_N), .CLEAR_N(CLEAR_N), .ENABLE(ENABLE),
            .fifo(bus), .TX(tx), .BUSY(busy)
        );

        // FIFO with one cycle read latency, cleared by the shared CLEAR_N net.
        assign bus.F_EMPTY_N = (rdPtr < wrCount);
        always @(posedge CLOCK) begin
            if (!CLEAR_N)
                rdPtr <= wrCount;
            else if (bus.READ && rdPtr < wrCount) begin
                bus.FIFO_DATA <= wordLog[rdPtr];
                rdPtr <= rdPtr + 1;
            end
        end

        always @(negedge CLOCK) begin : monitor
            bit         eTx;
            bit         eRead;
            bit         active;
            bit         v;
            logic [7:0] w;
            if (!RESET_N) begin
                expTx.delete();
                checkOutput($sformatf("rstTx%0d", G), tx, 1);
                checkOutput($sformatf("rstRead%0d", G), bus.READ, 0);
                checkOutput($sformatf("rstBusy%0d", G), busy, 0);
            end else begin
                active = (expTx.size() != 0);
                eTx = 1'b1;
                if (active) eTx = expTx.pop_front();
                eRead = !active && ENABLE && CLEAR_N && (modelPtr < wrCount);
                checkOutput($sformatf("tx%0d", G), tx, eTx);
                checkOutput($sformatf("read%0d", G), bus.READ, eRead);
                checkOutput($sformatf("busy%0d", G), busy, active || eRead);
                if (bus.READ) dutReads++;
                if (!CLEAR_N) begin
                    expTx.delete();
                    modelPtr = wrCount;
                end else if (eRead) begin
                    w = wordLog[modelPtr];
                    modelPtr++;
                    expTx.push_back(1'b1);
                    for (int b = 0; b < NBITS; b++) begin
                        if (b == 0)                      v = 1'b0;
                        else if (b <= 8)                 v = w[b-1];
                        else if (PAR != 0 && b == 9)     v = (^w) ^ (PAR == 2);
                        else                             v = 1'b1;
                        for (int k = 0; k < CLK_DIV; k++) expTx.push_back(v);
                    end
                end
            end
        end
    end

    function automatic bit modelsIdle();
        return gInst[0].expTx.size() == 0 && gInst[0].modelPtr == wrCount &&
               gInst[1].expTx.size() == 0 && gInst[1].modelPtr == wrCount &&
               gInst[2].expTx.size() == 0 && gInst[2].modelPtr == wrCount;
    endfunction

    task automatic applyStimulus(input logic [7:0] word);
        @(posedge CLOCK);
        #2;
        wordLog.push_back(word);
        wrCount++;
    endtask

    task automatic waitDrain(input int maxCycles);
        int n = 0;
        while (!modelsIdle() && n < maxCycles) begin
            @(posedge CLOCK);
            n++;
        end
        checkOutput("drained", modelsIdle(), 1);
        repeat (3) @(posedge CLOCK);
        #2;
    endtask

    task automatic waitRead0();
        int n = 0;
        do begin
            @(negedge CLOCK);
            n++;
        end while (!gInst[0].bus.READ && n < 100);
        checkOutput("readSeen", gInst[0].bus.READ, 1);
    endtask

    initial begin
        int r0, r1, r2;
        repeat (3) @(posedge CLOCK);
        #2 RESET_N = 1'b1;
        ENABLE = 1'b1;
        repeat (100) @(posedge CLOCK);

        applyStimulus(8'hA5);
        waitDrain(400);
        applyStimulus(8'h07);
        waitDrain(400);
        for (int i = 0; i < 32; i++) applyStimulus(8'(i));
        waitDrain(4000);

        // No pop while disabled; a frame started before ENABLE drops completes.
        ENABLE = 1'b0;
        r0 = gInst[0].dutReads;
        r1 = gInst[1].dutReads;
        r2 = gInst[2].dutReads;
        applyStimulus(8'h3C);
        applyStimulus(8'hC3);
        repeat (30) @(posedge CLOCK);
        checkOutput("disRead0", gInst[0].dutReads - r0, 0);
        checkOutput("disRead1", gInst[1].dutReads - r1, 0);
        checkOutput("disRead2", gInst[2].dutReads - r2, 0);
        #2 ENABLE = 1'b1;
        repeat (5) @(posedge CLOCK);
        #2 ENABLE = 1'b0;
        repeat (80) @(posedge CLOCK);
        checkOutput("dropRead0", gInst[0].dutReads - r0, 1);
        checkOutput("dropRead1", gInst[1].dutReads - r1, 1);
        checkOutput("dropRead2", gInst[2].dutReads - r2, 1);
        #2 ENABLE = 1'b1;
        waitDrain(400);
        checkOutput("reRead0", gInst[0].dutReads - r0, 2);

        // CLEAR_N during the first cycle of data bit 3 of instance 0.
        applyStimulus(8'h96);
        waitRead0();
        repeat (18) @(posedge CLOCK);
        #2 CLEAR_N = 1'b0;
        @(posedge CLOCK);
        #1 checkOutput("clrTx", gInst[0].tx, 1);
        #1 CLEAR_N = 1'b1;
        waitDrain(200);

        // Asynchronous reset in the stop bit of instance 0 (parity bit 0 of instance 1).
        applyStimulus(8'h5A);
        waitRead0();
        repeat (39) @(posedge CLOCK);
        #2 RESET_N = 1'b0;
        #1;
        checkOutput("asyncTx0", gInst[0].tx, 1);
        checkOutput("asyncTx1", gInst[1].tx, 1);
        checkOutput("asyncTx2", gInst[2].tx, 1);
        repeat (2) @(posedge CLOCK);
        #2 RESET_N = 1'b1;
        waitDrain(100);

        for (int i = 0; i < 24; i++) begin
            applyStimulus(8'($urandom_range(0, 255)));
            repeat ($urandom_range(0, 60)) @(posedge CLOCK);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge CLOCK);
                #2 ENABLE = ~ENABLE;
            end
        end
        @(posedge CLOCK);
        #2 ENABLE = 1'b1;
        waitDrain(5000);

        checkOutput("reads0", gInst[0].dutReads, wrCount);
        checkOutput("reads1", gInst[1].dutReads, wrCount);
        checkOutput("reads2", gInst[2].dutReads, wrCount);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end
endmodule
